// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver, the receive side of uart_tx.
// Frame: start bit (0), DATA_W data bits LSB first, optional parity bit, stop bit (1).
// The idle line is high.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   baud_sel   bit period select, latched at each start edge (0=115200 .. 3=9600)
//   rx_din     asynchronous serial input pin
//   dout       received byte, held until the next frame completes
//   dout_vld   one-cycle strobe when dout updates
//   parity_err parity mismatch, coincident with dout_vld (0 when PARITY_EN=0)
//   frame_err  stop bit sampled low, coincident with dout_vld
//   rx_busy    high while a frame is being received
module uart_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BAUD_115200 = 434,
    parameter int unsigned BAUD_57600  = 868,
    parameter int unsigned BAUD_38400  = 1302,
    parameter int unsigned BAUD_9600   = 5208,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        baud_sel,
    input  logic              rx_din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              parity_err,
    output logic              frame_err,
    output logic              rx_busy
);

    localparam int unsigned CNT_W = 13;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t              state;
    logic                rx_s1;
    logic                rx_s2;
    logic                rx_s3;
    logic [CNT_W-1:0]    period;
    logic [CNT_W-1:0]    period_dec;
    logic [CNT_W-1:0]    cnt0;
    logic [IDX_W-1:0]    cnt1;
    logic [DATA_W-1:0]   shift_reg;
    logic                par_bit;
    logic                par_exp;
    logic                start_det;
    logic                sample;
    logic                period_end;

    always_comb begin
        period_dec = CNT_W'(BAUD_115200);
        unique case (baud_sel)
            2'd0: period_dec = CNT_W'(BAUD_115200);
            2'd1: period_dec = CNT_W'(BAUD_57600);
            2'd2: period_dec = CNT_W'(BAUD_38400);
            2'd3: period_dec = CNT_W'(BAUD_9600);
            default: period_dec = CNT_W'(BAUD_115200);
        endcase
    end

    // Falling edge on the synchronised line.
    assign start_det  = rx_s3 & ~rx_s2;
    // Mid-bit sample point and last cycle of the bit, both against the latched period.
    assign sample     = (cnt0 == (period >> 1) - CNT_W'(1));
    assign period_end = (cnt0 == period - CNT_W'(1));
    assign par_exp    = (PARITY_ODD != 0) ? ~^shift_reg : ^shift_reg;
    assign rx_busy    = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            period     <= CNT_W'(BAUD_115200);
            cnt0       <= '0;
            cnt1       <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            dout       <= '0;
            dout_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx_din;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            dout_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == StIdle || period_end) begin
                cnt0 <= '0;
            end else begin
                cnt0 <= cnt0 + CNT_W'(1);
            end

            case (state)
                StIdle: begin
                    if (start_det) begin
                        period <= period_dec;
                        cnt1   <= '0;
                        state  <= StStart;
                    end
                end
                StStart: begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (sample && rx_s2) begin
                        state <= StIdle;
                    end else if (period_end) begin
                        cnt1  <= '0;
                        state <= StData;
                    end
                end
                StData: begin
                    if (sample) begin
                        shift_reg[cnt1] <= rx_s2;
                    end
                    if (period_end) begin
                        if (cnt1 == IDX_W'(DATA_W - 1)) begin
                            state <= (PARITY_EN != 0) ? StParity : StStop;
                        end else begin
                            cnt1 <= cnt1 + IDX_W'(1);
                        end
                    end
                end
                StParity: begin
                    if (sample) begin
                        par_bit <= rx_s2;
                    end
                    if (period_end) begin
                        state <= StStop;
                    end
                end
                StStop: begin
                    // Deliver mid stop bit and return to idle so a back-to-back start
                    // edge at the end of this stop bit is still seen.
                    if (sample) begin
                        dout       <= shift_reg;
                        dout_vld   <= 1'b1;
                        frame_err  <= ~rx_s2;
                        parity_err <= (PARITY_EN != 0) && (par_bit != par_exp);
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance without parity, one with odd parity, each on its own line.
// The three slower bit periods are shortened so the whole run stays small; sel 0 keeps 434.
module tb_uart_rx;

    localparam int unsigned P0 = 434;
    localparam int unsigned P1 = 64;
    localparam int unsigned P2 = 75;
    localparam int unsigned P3 = 101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel0, sel1;
    logic       rx0, rx1;
    logic [7:0] dout0, dout1;
    logic       vld0, vld1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_W(8), .BAUD_115200(P0), .BAUD_57600(P1), .BAUD_38400(P2), .BAUD_9600(P3),
        .PARITY_EN(0), .PARITY_ODD(1)
    ) u_dut_np (
        .clk(clk), .rst_n(rst_n), .baud_sel(sel0), .rx_din(rx0), .dout(dout0),
        .dout_vld(vld0), .parity_err(perr0), .frame_err(ferr0), .rx_busy(busy0)
    );

    uart_rx #(
        .DATA_W(8), .BAUD_115200(P0), .BAUD_57600(P1), .BAUD_38400(P2), .BAUD_9600(P3),
        .PARITY_EN(1), .PARITY_ODD(1)
    ) u_dut_po (
        .clk(clk), .rst_n(rst_n), .baud_sel(sel1), .rx_din(rx1), .dout(dout1),
        .dout_vld(vld1), .parity_err(perr1), .frame_err(ferr1), .rx_busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    int stray  = 0;
    // Entries are {frame_err, parity_err, dout}.
    logic [9:0] obs0[$], obs1[$], exp0[$], exp1[$];

    always @(negedge clk) begin
        if (vld0) obs0.push_back({ferr0, perr0, dout0});
        else if (perr0 || ferr0) stray++;
        if (vld1) obs1.push_back({ferr1, perr1, dout1});
        else if (perr1 || ferr1) stray++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int period_of(input logic [1:0] s);
        case (s)
            2'd0: return P0;
            2'd1: return P1;
            2'd2: return P2;
            default: return P3;
        endcase
    endfunction

    // Reference: odd parity means data ones plus parity bit is an odd total.
    function automatic logic [9:0] model(input logic [7:0] d, input bit par_en,
                                         input bit par_b, input bit stop_b);
        int ones;
        bit pe;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        pe = par_en && (((ones + int'(par_b)) % 2) == 0);
        return {~stop_b, pe, d};
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par_en,
                                               input bit par_b, input bit stop_b);
        logic [10:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (par_en) begin
            b[9]  = par_b;
            b[10] = stop_b;
        end else begin
            b[9] = stop_b;
        end
        return b;
    endfunction

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic drive(input int which, input logic [10:0] bits, input int nbits, input int per);
        for (int i = 0; i < nbits; i++) begin
            set_line(which, bits[i]);
            repeat (per) @(negedge clk);
        end
        set_line(which, 1'b1);
    endtask

    task automatic send(input int which, input logic [7:0] d, input bit par_b, input bit stop_b,
                        input logic [1:0] sel, input int gap);
        bit pe_en;
        int per;
        pe_en = (which == 1);
        per   = period_of(sel);
        if (which == 0) begin
            sel0 = sel;
            exp0.push_back(model(d, 1'b0, par_b, stop_b));
        end else begin
            sel1 = sel;
            exp1.push_back(model(d, 1'b1, par_b, stop_b));
        end
        drive(which, frame_bits(d, pe_en, par_b, stop_b), 10 + int'(pe_en), per);
        repeat (gap * per) @(negedge clk);
    endtask

    task automatic verify(input int which, input string tag);
        logic [9:0] o[$];
        logic [9:0] e[$];
        logic [7:0] dv;
        if (which == 0) begin
            o = obs0; e = exp0; dv = dout0;
            obs0.delete(); exp0.delete();
        end else begin
            o = obs1; e = exp1; dv = dout1;
            obs1.delete(); exp1.delete();
        end
        check($sformatf("%s.count", tag), 32'(o.size()), 32'(e.size()));
        for (int k = 0; k < e.size(); k++) begin
            if (k < o.size()) begin
                check($sformatf("%s[%0d].dout", tag, k), 32'(o[k][7:0]), 32'(e[k][7:0]));
                check($sformatf("%s[%0d].perr", tag, k), 32'(o[k][8]), 32'(e[k][8]));
                check($sformatf("%s[%0d].ferr", tag, k), 32'(o[k][9]), 32'(e[k][9]));
            end
        end
        if (e.size() > 0) check($sformatf("%s.hold", tag), 32'(dv), 32'(e[e.size()-1][7:0]));
    endtask

    initial begin
        logic [7:0] d;
        bit         pb, sb;
        logic [1:0] s;
        int         w;

        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; sel0 = 2'd0; sel1 = 2'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx0 = 1'($urandom); rx1 = 1'($urandom);
        end
        check("rst.dout0", 32'(dout0), 32'h0);
        check("rst.dout1", 32'(dout1), 32'h0);
        check("rst.flags0", 32'({vld0, perr0, ferr0, busy0}), 32'h0);
        check("rst.flags1", 32'({vld1, perr1, ferr1, busy1}), 32'h0);
        check("rst.nvld", 32'(obs0.size() + obs1.size()), 32'h0);
        rx0 = 1'b1; rx1 = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frame at sel 0, busy checked mid-frame.
        fork
            send(0, 8'hA5, 1'b0, 1'b1, 2'd0, 1);
            begin
                repeat (P0 * 3) @(negedge clk);
                check("a5.busy_mid", 32'(busy0), 32'h1);
            end
        join
        check("a5.busy_after", 32'(busy0), 32'h0);
        verify(0, "a5");

        // Back-to-back frames, no idle gap.
        send(0, 8'h00, 1'b0, 1'b1, 2'd3, 0);
        send(0, 8'hFF, 1'b0, 1'b1, 2'd3, 1);
        verify(0, "b2b");

        // Odd parity: 0x03 has two ones so the parity bit must be 1.
        send(1, 8'h03, 1'b1, 1'b1, 2'd2, 1);
        verify(1, "par_ok");
        send(1, 8'h03, 1'b0, 1'b1, 2'd2, 1);
        verify(1, "par_bad");

        // Stop bit low.
        send(0, 8'h5A, 1'b0, 1'b0, 2'd0, 2);
        verify(0, "stop0");

        // Short low glitch while idle.
        sel0 = 2'd0;
        rx0 = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch.busy_in", 32'(busy0), 32'h1);
        repeat (50) @(negedge clk);
        rx0 = 1'b1;
        repeat (P0) @(negedge clk);
        check("glitch.busy_out", 32'(busy0), 32'h0);
        verify(0, "glitch");

        // Reset in the middle of data bit 4 (a 1 for 0x96, so no edge on release).
        sel0 = 2'd0;
        fork
            drive(0, frame_bits(8'h96, 1'b0, 1'b0, 1'b1), 6, P0);
            begin
                repeat (P0 * 5 + P0 / 2) @(negedge clk);
                check("rstmid.busy", 32'(busy0), 32'h1);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("rstmid.dout", 32'(dout0), 32'h0);
                check("rstmid.busy0", 32'(busy0), 32'h0);
                rst_n = 1'b1;
            end
        join
        repeat (P0) @(negedge clk);
        send(0, 8'h3C, 1'b0, 1'b1, 2'd0, 1);
        verify(0, "after_rst");

        // Break: line held low; one all-zero frame with frame_err, then nothing.
        sel0 = 2'd1;
        exp0.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
        rx0 = 1'b0;
        repeat (P1 * 25) @(negedge clk);
        check("break.busy", 32'(busy0), 32'h0);
        rx0 = 1'b1;
        repeat (P1 * 2) @(negedge clk);
        verify(0, "break");

        // Random frames; baud_sel is scrambled mid-frame and must be ignored.
        for (int i = 0; i < 12; i++) begin
            w  = i % 2;
            d  = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            s  = 2'($urandom_range(1, 3));
            fork
                send(w, d, pb, sb, s, 1);
                begin
                    repeat (20) @(negedge clk);
                    if (w == 0) sel0 = 2'($urandom);
                    else sel1 = 2'($urandom);
                end
            join
            verify(w, $sformatf("rand%0d", i));
        end

        check("stray_flags", 32'(stray), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's uart_tx.
- Frame format: 1 start bit (0), DATA_W data bits LSB first, optional parity bit, 1 stop bit (1). Idle line is high.
- Shares the uart_tx baud-select encoding and parity convention, so a tx/rx pair on the same clk interoperates.
- Sits between the external RX pin and the user-side byte consumer. Delivers each byte with a 1-cycle valid strobe plus error flags.

Parameters:
- DATA_W, 8, data bits per frame.
- BAUD_115200, 434, clk cycles per bit for sel 0 (50 MHz clk).
- BAUD_57600, 868, clk cycles per bit for sel 1.
- BAUD_38400, 1302, clk cycles per bit for sel 2.
- BAUD_9600, 5208, clk cycles per bit for sel 3.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 1, 1 = odd parity (parity bit = ~^data); 0 = even parity (^data).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- baud_sel  in  2  bit-period select: 0=115200, 1=57600, 2=38400, 3=9600.
- rx_din  in  1  asynchronous serial input pin.
- dout  out  DATA_W  received byte; holds until the next frame completes.
- dout_vld  out  1  one-cycle pulse when dout is updated.
- parity_err  out  1  one-cycle pulse coincident with dout_vld; parity mismatch (0 when PARITY_EN=0).
- frame_err  out  1  one-cycle pulse coincident with dout_vld; stop bit sampled 0.
- rx_busy  out  1  high while state != IDLE.

Behaviour:
- Reset values: dout=0, dout_vld=0, parity_err=0, frame_err=0, rx_busy=0, state=IDLE. Synchronizer flops reset to 1.
- Input sync: rx_din passes through 2 flops (rx_s1, rx_s2), then a third flop rx_s3 for edge detect. Start detect = rx_s3 & ~rx_s2 (falling edge).
- Baud latch: on start detect, baud_sel is decoded and latched into a 13-bit period register. baud_sel changes mid-frame have no effect until the next frame.
- Counters:
  - cnt0 (13 bit) counts 0..period-1, wraps, and increments only when state != IDLE.
  - cnt1 is the bit index.
  - Sample point is cnt0 == period/2 - 1 (integer division).
- State machine:
  - IDLE -> START on start detect; cnt0 cleared.
  - START: at the sample point, if rx_s2==1 it is a glitch -> IDLE (no outputs). If rx_s2==0, cnt0 keeps running to the period end, then -> DATA.
  - DATA: at each sample point, shift_reg[cnt1] <= rx_s2 (LSB first). Each period end increments cnt1. After the period end of bit DATA_W-1: -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: at the sample point, capture the parity bit; at the period end -> STOP.
  - STOP: at the sample point, load dout <= shift_reg and pulse dout_vld for 1 cycle. frame_err = ~rx_s2. parity_err = PARITY_EN & (captured bit != expected). Then -> IDLE immediately (mid-stop), so a back-to-back start edge is not missed.
- Error handling: a byte with an error is still delivered on dout. The error flags qualify it.
- Latency: dout_vld occurs 2 sync cycles plus about (1 + DATA_W + PARITY_EN + 0.5) bit periods after the start edge at the pin.
- Break condition (line held low): frame_err is flagged with dout=0. The FSM then waits in IDLE for a fresh falling edge; a continuous low produces no further frames.
- Reset mid-frame: everything returns to reset values immediately, and no dout_vld is issued for the partial frame.
- rx_busy is combinational from state; it is 0 in the cycle after the STOP transition.

Test Plan:
- Reset: rst_n low with rx_din toggling -> all outputs 0, no dout_vld.
- baud_sel=0, PARITY_EN=0, frame 0xA5 at 434 clk/bit -> a single dout_vld with dout=0xA5, parity_err=0, frame_err=0.
- baud_sel=3, back-to-back frames 0x00 then 0xFF with no idle gap -> two dout_vld pulses, with dout 0x00 then 0xFF.
- PARITY_EN=1, PARITY_ODD=1:
  - Byte 0x03 with parity bit 1 -> parity_err=0.
  - Same byte with parity bit 0 -> parity_err=1, dout=0x03.
- Stop bit driven 0 on byte 0x5A -> dout=0x5A, frame_err=1. A 100-cycle low glitch (< 217) while IDLE at sel 0 -> returns to IDLE, no dout_vld.
- Reset asserted at data bit 4, then released, then a clean frame 0x3C -> exactly one dout_vld, with dout=0x3C.
